// File: rtl/param_counter_if.sv
// rtl/param_counter_if.sv - control and status bundle for param_counter
interface param_counter_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             up_dn;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up_dn, clear, load, load_val,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up_dn, clear, load, load_val,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/param_counter.sv
// rtl/param_counter.sv - up/down counter with modulus, prescaler, load/clear and wrap/saturate
module param_counter #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               PRESCALE = 1,
    parameter bit               SATURATE = 1'b0
) (
    input logic             clk,
    input logic             rst,
    param_counter_if.slave  bus
);
    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             tick;

    // The prescaler only reaches its last phase while enabled, so tick implies en.
    assign tick = bus.en && (pre_q == PRE_LAST);

    // Next state: clear beats load beats a counting tick; wrap is a one-cycle pulse.
    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (bus.clear) begin
            count_d = '0;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
            pre_d   = '0;
        end else if (bus.en) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                if (bus.up_dn) begin
                    if (count_q == MAX_VAL) begin
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                        if (!SATURATE) count_d = '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        wrap_d = 1'b1;
                        ovf_d  = 1'b1;
                        if (!SATURATE) count_d = MAX_VAL;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;
    // Terminal count looks at the direction requested right now, not at the last tick.
    assign bus.tc    = bus.up_dn ? (count_q == MAX_VAL) : (count_q == '0);
endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - scoreboard bench for param_counter across four parameter sets
module tb_param_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_counter_if #(.WIDTH(32)) if0 ();
    param_counter_if #(.WIDTH(4))  if1 ();
    param_counter_if #(.WIDTH(4))  if2 ();
    param_counter_if #(.WIDTH(4))  if3 ();

    param_counter #(.WIDTH(32)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    param_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    param_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

    typedef struct {
        int          id;
        logic [31:0] count;
        logic        tc;
        logic        wrap;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic idle_all(input logic u);
        if0.en = 1'b0; if0.clear = 1'b0; if0.load = 1'b0; if0.up_dn = u; if0.load_val = '0;
        if1.en = 1'b0; if1.clear = 1'b0; if1.load = 1'b0; if1.up_dn = u; if1.load_val = '0;
        if2.en = 1'b0; if2.clear = 1'b0; if2.load = 1'b0; if2.up_dn = u; if2.load_val = '0;
        if3.en = 1'b0; if3.clear = 1'b0; if3.load = 1'b0; if3.up_dn = u; if3.load_val = '0;
    endtask

    // Drive one cycle of stimulus on one counter and queue the state expected after the edge.
    task automatic step(input int id, input string nm, input logic r, input logic e,
                        input logic u, input logic c, input logic l, input logic [31:0] lv,
                        input logic [31:0] xc, input logic xt, input logic xw, input logic xo);
        exp_t x;
        @(negedge clk);
        rst = r;
        idle_all(u);
        case (id)
            0: begin if0.en = e; if0.clear = c; if0.load = l; if0.load_val = lv; end
            1: begin if1.en = e; if1.clear = c; if1.load = l; if1.load_val = lv[3:0]; end
            2: begin if2.en = e; if2.clear = c; if2.load = l; if2.load_val = lv[3:0]; end
            default: begin if3.en = e; if3.clear = c; if3.load = l; if3.load_val = lv[3:0]; end
        endcase
        x.id = id; x.count = xc; x.tc = xt; x.wrap = xw; x.ovf = xo; x.name = nm;
        sb.push_back(x);
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t        x;
        logic [31:0] ac;
        logic        at, aw, ao;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                case (x.id)
                    0: begin ac = if0.count; at = if0.tc; aw = if0.wrap; ao = if0.ovf; end
                    1: begin ac = {28'd0, if1.count}; at = if1.tc; aw = if1.wrap; ao = if1.ovf; end
                    2: begin ac = {28'd0, if2.count}; at = if2.tc; aw = if2.wrap; ao = if2.ovf; end
                    default: begin ac = {28'd0, if3.count}; at = if3.tc; aw = if3.wrap; ao = if3.ovf; end
                endcase
                n_checks++;
                if (ac !== x.count || at !== x.tc || aw !== x.wrap || ao !== x.ovf) begin
                    n_fail++;
                    $display("FAIL %s: got count=%0h tc=%b wrap=%b ovf=%b, expected count=%0h tc=%b wrap=%b ovf=%b",
                             x.name, ac, at, aw, ao, x.count, x.tc, x.wrap, x.ovf);
                end
            end
        end
    end

    initial begin
        idle_all(1'b1);
        //    id name           rst en up clr ld load_val       count        tc wr ov
        // Default 32-bit counter: reset, count, mid-count reset, wrap at all-ones
        step(0, "t1_reset",      1, 1, 1, 0, 0, 32'd0,        32'd0,        0, 0, 0);
        step(0, "t1_cnt1",       0, 1, 1, 0, 0, 32'd0,        32'd1,        0, 0, 0);
        step(0, "t1_cnt2",       0, 1, 1, 0, 0, 32'd0,        32'd2,        0, 0, 0);
        step(0, "t1_cnt3",       0, 1, 1, 0, 0, 32'd0,        32'd3,        0, 0, 0);
        step(0, "t1_midreset",   1, 1, 1, 0, 0, 32'd0,        32'd0,        0, 0, 0);
        step(0, "t1_recnt1",     0, 1, 1, 0, 0, 32'd0,        32'd1,        0, 0, 0);
        step(0, "t1_recnt2",     0, 1, 1, 0, 0, 32'd0,        32'd2,        0, 0, 0);
        step(0, "t1_loadmax",    0, 0, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
        step(0, "t1_wrap32",     0, 1, 1, 0, 0, 32'd0,        32'd0,        0, 1, 1);
        step(0, "t1_hold",       0, 0, 1, 0, 0, 32'd0,        32'd0,        0, 0, 1);
        // Modulus 10, wrapping both directions, load clamp
        step(1, "t2_load8",      0, 0, 1, 0, 1, 32'd8,        32'd8,        0, 0, 0);
        step(1, "t2_up9",        0, 1, 1, 0, 0, 32'd0,        32'd9,        1, 0, 0);
        step(1, "t2_wrap0",      0, 1, 1, 0, 0, 32'd0,        32'd0,        0, 1, 1);
        step(1, "t2_up1",        0, 1, 1, 0, 0, 32'd0,        32'd1,        0, 0, 1);
        step(1, "t2_dn_hold",    0, 0, 0, 0, 0, 32'd0,        32'd1,        0, 0, 1);
        step(1, "t2_dn0",        0, 1, 0, 0, 0, 32'd0,        32'd0,        1, 0, 1);
        step(1, "t2_dnwrap9",    0, 1, 0, 0, 0, 32'd0,        32'd9,        0, 1, 1);
        step(1, "t2_tc_up_dir",  0, 0, 1, 0, 0, 32'd0,        32'd9,        1, 0, 1);
        step(1, "t5_clamp13",    0, 1, 1, 0, 1, 32'd13,       32'd9,        1, 0, 1);
        step(1, "t5_load4",      0, 0, 1, 0, 1, 32'd4,        32'd4,        0, 0, 1);
        step(1, "t2_clear",      0, 0, 1, 1, 0, 32'd0,        32'd0,        0, 0, 0);
        // Saturating variant
        step(2, "t3_load8",      0, 0, 1, 0, 1, 32'd8,        32'd8,        0, 0, 0);
        step(2, "t3_up9",        0, 1, 1, 0, 0, 32'd0,        32'd9,        1, 0, 0);
        step(2, "t3_sat_a",      0, 1, 1, 0, 0, 32'd0,        32'd9,        1, 1, 1);
        step(2, "t3_sat_b",      0, 1, 1, 0, 0, 32'd0,        32'd9,        1, 1, 1);
        step(2, "t3_idle",       0, 0, 1, 0, 0, 32'd0,        32'd9,        1, 0, 1);
        step(2, "t3_dn8",        0, 1, 0, 0, 0, 32'd0,        32'd8,        0, 0, 1);
        step(2, "t3_clear",      0, 0, 0, 1, 0, 32'd0,        32'd0,        1, 0, 0);
        step(2, "t3_sat_low",    0, 1, 0, 0, 0, 32'd0,        32'd0,        1, 1, 1);
        step(2, "t3_clear_en",   0, 1, 0, 1, 0, 32'd0,        32'd0,        1, 0, 0);
        // Prescale by 3, enable stall, load resets the prescaler
        step(3, "t4_p1",         0, 1, 1, 0, 0, 32'd0,        32'd0,        0, 0, 0);
        step(3, "t4_p2",         0, 1, 1, 0, 0, 32'd0,        32'd0,        0, 0, 0);
        step(3, "t4_tick1",      0, 1, 1, 0, 0, 32'd0,        32'd1,        0, 0, 0);
        step(3, "t4_p4",         0, 1, 1, 0, 0, 32'd0,        32'd1,        0, 0, 0);
        step(3, "t4_p5",         0, 1, 1, 0, 0, 32'd0,        32'd1,        0, 0, 0);
        step(3, "t4_tick2",      0, 1, 1, 0, 0, 32'd0,        32'd2,        0, 0, 0);
        step(3, "t4_p7",         0, 1, 1, 0, 0, 32'd0,        32'd2,        0, 0, 0);
        step(3, "t4_stall_a",    0, 0, 1, 0, 0, 32'd0,        32'd2,        0, 0, 0);
        step(3, "t4_stall_b",    0, 0, 1, 0, 0, 32'd0,        32'd2,        0, 0, 0);
        step(3, "t4_p10",        0, 1, 1, 0, 0, 32'd0,        32'd2,        0, 0, 0);
        step(3, "t4_tick3_late", 0, 1, 1, 0, 0, 32'd0,        32'd3,        0, 0, 0);
        step(3, "t4_p12",        0, 1, 1, 0, 0, 32'd0,        32'd3,        0, 0, 0);
        step(3, "t5_load5",      0, 1, 1, 0, 1, 32'd5,        32'd5,        0, 0, 0);
        step(3, "t5_pre_a",      0, 1, 1, 0, 0, 32'd0,        32'd5,        0, 0, 0);
        step(3, "t5_pre_b",      0, 1, 1, 0, 0, 32'd0,        32'd5,        0, 0, 0);
        step(3, "t5_pre_tick",   0, 1, 1, 0, 0, 32'd0,        32'd6,        0, 0, 0);
        // Priority checks
        step(1, "t6_load7",      0, 0, 1, 0, 1, 32'd7,        32'd7,        0, 0, 0);
        step(1, "t6_clr_ld_en",  0, 1, 1, 1, 1, 32'd3,        32'd0,        0, 0, 0);
        step(1, "t6_dnwrap",     0, 1, 0, 0, 0, 32'd0,        32'd9,        0, 1, 1);
        step(1, "t6_rst_clr",    1, 1, 1, 1, 1, 32'd3,        32'd0,        0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_all(1'b1);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
